// File: rtl/mem_dbus_stage.sv
// MEM stage: executes byte/half/word loads and stores over a req/ack data bus, stalling the pipe meanwhile.
// Optional build macro MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses without touching the bus.
module mem_dbus_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic        whilo_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        cp0_we_i,
  input  logic [4:0]  cp0_waddr_i,
  input  logic [31:0] cp0_wdata_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        cp0_we_o,
  output logic [4:0]  cp0_waddr_o,
  output logic [31:0] cp0_wdata_o,
  output logic        stallreq,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        bus_err
);

  localparam logic [7:0] OP_LB  = 8'b11100000;
  localparam logic [7:0] OP_LH  = 8'b11100001;
  localparam logic [7:0] OP_LW  = 8'b11100011;
  localparam logic [7:0] OP_LBU = 8'b11100100;
  localparam logic [7:0] OP_LHU = 8'b11100101;
  localparam logic [7:0] OP_SB  = 8'b11101000;
  localparam logic [7:0] OP_SH  = 8'b11101001;
  localparam logic [7:0] OP_SW  = 8'b11101011;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [7:0]  count;
  logic        abort;
  logic        bus_err_q;
  logic [31:0] load_data;

  logic        is_byte, is_half, is_word, is_load, is_store, is_mem;
  logic        misalign, start;
  logic [3:0]  sel_next;
  logic [31:0] wdata_next;
  logic        unused_stall_bits;

  assign unused_stall_bits = ^{stall[5], stall[3:0]};

  assign is_byte  = (aluop_i == OP_LB) || (aluop_i == OP_LBU) || (aluop_i == OP_SB);
  assign is_half  = (aluop_i == OP_LH) || (aluop_i == OP_LHU) || (aluop_i == OP_SH);
  assign is_word  = (aluop_i == OP_LW) || (aluop_i == OP_SW);
  assign is_store = (aluop_i == OP_SB) || (aluop_i == OP_SH) || (aluop_i == OP_SW);
  assign is_load  = is_byte || is_half || is_word ? !is_store : 1'b0;
  assign is_mem   = is_load || is_store;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (is_half && mem_addr_i[0]) || (is_word && (mem_addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign start = is_mem && !misalign;

  // Big-endian lanes: address offset 0 lives in bits [31:24].
  always_comb begin
    sel_next   = 4'b1111;
    wdata_next = reg2_i;
    if (is_byte) begin
      wdata_next = {4{reg2_i[7:0]}};
      case (mem_addr_i[1:0])
        2'b00:   sel_next = 4'b1000;
        2'b01:   sel_next = 4'b0100;
        2'b10:   sel_next = 4'b0010;
        default: sel_next = 4'b0001;
      endcase
    end else if (is_half) begin
      wdata_next = {2{reg2_i[15:0]}};
      sel_next   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
    end
  end

  function automatic logic [31:0] extract(input logic [7:0] op, input logic [1:0] off,
                                          input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'b00:   b = d[31:24];
      2'b01:   b = d[23:16];
      2'b10:   b = d[15:8];
      default: b = d[7:0];
    endcase
    h = off[1] ? d[15:0] : d[31:16];
    case (op)
      OP_LB:   extract = {{24{b[7]}}, b};
      OP_LBU:  extract = {24'd0, b};
      OP_LH:   extract = {{16{h[15]}}, h};
      OP_LHU:  extract = {16'd0, h};
      default: extract = d;
    endcase
  endfunction

  // Bus fields stay put from issue until the next access, so dbus_we still tells load from store in HOLD.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= 8'd0;
      abort      <= 1'b0;
      bus_err_q  <= 1'b0;
      load_data  <= 32'd0;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_sel   <= 4'd0;
      dbus_addr  <= 32'd0;
      dbus_wdata <= 32'd0;
    end else begin
      bus_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dbus_req   <= 1'b1;
            dbus_we    <= is_store;
            dbus_sel   <= sel_next;
            dbus_addr  <= {mem_addr_i[31:2], 2'b00};
            dbus_wdata <= wdata_next;
            count      <= 8'd0;
            abort      <= 1'b0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (dbus_ack) begin
            load_data <= extract(aluop_i, mem_addr_i[1:0], dbus_rdata);
            dbus_req  <= 1'b0;
            state     <= HOLD;
          end else if (count == LAST_COUNT) begin
            dbus_req  <= 1'b0;
            abort     <= 1'b1;
            bus_err_q <= 1'b1;
            state     <= HOLD;
          end else begin
            count <= count + 8'd1;
          end
        end
        HOLD: begin
          if (!stall[4]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Everything reads as zero while reset is held; a memory op suppresses its write until HOLD.
  always_comb begin
    wd_o        = 5'd0;
    wreg_o      = 1'b0;
    wdata_o     = 32'd0;
    whilo_o     = 1'b0;
    hi_o        = 32'd0;
    lo_o        = 32'd0;
    cp0_we_o    = 1'b0;
    cp0_waddr_o = 5'd0;
    cp0_wdata_o = 32'd0;
    stallreq    = 1'b0;
    bus_err     = 1'b0;
    if (rst) begin
      wd_o        = wd_i;
      wreg_o      = wreg_i;
      wdata_o     = wdata_i;
      whilo_o     = whilo_i;
      hi_o        = hi_i;
      lo_o        = lo_i;
      cp0_we_o    = cp0_we_i;
      cp0_waddr_o = cp0_waddr_i;
      cp0_wdata_o = cp0_wdata_i;
      bus_err     = bus_err_q;
      case (state)
        IDLE: begin
          if (is_mem) begin
            wreg_o = 1'b0;
            if (misalign) bus_err = 1'b1;
            else stallreq = 1'b1;
          end
        end
        BUSY: begin
          wreg_o   = 1'b0;
          stallreq = 1'b1;
        end
        HOLD: begin
          if (abort) wreg_o = 1'b0;
          else if (!dbus_we) wdata_o = load_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dbus_stage.sv
// Directed bench for mem_dbus_stage (TIMEOUT=4); covers the MEM_ALIGN_CHECK_EN path when that macro is defined.
module tb_mem_dbus_stage;

  localparam logic [7:0] OP_LB  = 8'b11100000;
  localparam logic [7:0] OP_LH  = 8'b11100001;
  localparam logic [7:0] OP_LW  = 8'b11100011;
  localparam logic [7:0] OP_LBU = 8'b11100100;
  localparam logic [7:0] OP_LHU = 8'b11100101;
  localparam logic [7:0] OP_SH  = 8'b11101001;
  localparam logic [7:0] OP_OR  = 8'b00100101;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic        whilo_i;
  logic [31:0] hi_i, lo_i;
  logic        cp0_we_i;
  logic [4:0]  cp0_waddr_i;
  logic [31:0] cp0_wdata_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o, lo_o;
  logic        cp0_we_o;
  logic [4:0]  cp0_waddr_o;
  logic [31:0] cp0_wdata_o;
  logic        stallreq, dbus_req, dbus_we;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_addr, dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        bus_err;

  int errors = 0;
  int checks = 0;

  mem_dbus_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .whilo_i(whilo_i), .hi_i(hi_i), .lo_i(lo_i),
    .cp0_we_i(cp0_we_i), .cp0_waddr_i(cp0_waddr_i), .cp0_wdata_i(cp0_wdata_i),
    .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
    .cp0_we_o(cp0_we_o), .cp0_waddr_o(cp0_waddr_o), .cp0_wdata_o(cp0_wdata_o),
    .stallreq(stallreq), .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_sel(dbus_sel),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack),
    .dbus_rdata(dbus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                               input logic wreg, input logic [31:0] wdata);
    aluop_i    = op;
    mem_addr_i = addr;
    reg2_i     = reg2;
    wreg_i     = wreg;
    wdata_i    = wdata;
    #1;
  endtask

  // Issues an access, checks the registered bus fields, acks after 'waits' extra BUSY cycles; ends in HOLD.
  task automatic runAccess(input string tag, input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] reg2, input logic wreg, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int waits, input logic exp_we,
                           input logic [3:0] exp_sel, input logic [31:0] exp_bus_wdata);
    logic [31:0] exp_addr;
    exp_addr = {addr[31:2], 2'b00};
    applyStimulus(op, addr, reg2, wreg, wdata);
    checkOutput({tag, " idle stallreq"}, stallreq, 1);
    checkOutput({tag, " idle req"}, dbus_req, 0);
    tick();
    checkOutput({tag, " busy req"}, dbus_req, 1);
    checkOutput({tag, " busy we"}, dbus_we, exp_we);
    checkOutput({tag, " busy sel"}, dbus_sel, exp_sel);
    checkOutput({tag, " busy addr"}, dbus_addr, exp_addr);
    checkOutput({tag, " busy wdata"}, dbus_wdata, exp_bus_wdata);
    checkOutput({tag, " busy stallreq"}, stallreq, 1);
    for (int i = 0; i < waits; i++) begin
      tick();
      checkOutput({tag, " wait req"}, dbus_req, 1);
      checkOutput({tag, " wait stallreq"}, stallreq, 1);
    end
    dbus_ack   = 1'b1;
    dbus_rdata = rdata;
    tick();
    dbus_ack   = 1'b0;
    dbus_rdata = 32'h0;
    #1;
    checkOutput({tag, " hold req"}, dbus_req, 0);
    checkOutput({tag, " hold stallreq"}, stallreq, 0);
  endtask

  initial begin
    rst = 1'b0; stall = 6'd0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
    wd_i = 5'd7; whilo_i = 1'b1; hi_i = 32'hAAAA0001; lo_i = 32'h5555_0002;
    cp0_we_i = 1'b1; cp0_waddr_i = 5'd12; cp0_wdata_i = 32'hC0C0_0003;
    applyStimulus(OP_LW, 32'h100, 32'h0, 1'b1, 32'h55);
    tick();
    tick();
    checkOutput("reset req", dbus_req, 0);
    checkOutput("reset sel", dbus_sel, 0);
    checkOutput("reset stallreq", stallreq, 0);
    checkOutput("reset wreg_o", wreg_o, 0);
    checkOutput("reset wdata_o", wdata_o, 0);
    checkOutput("reset hi_o", hi_o, 0);
    checkOutput("reset bus_err", bus_err, 0);

    rst = 1'b1;
    applyStimulus(OP_OR, 32'h0, 32'h0, 1'b1, 32'h12345678);
    checkOutput("pass wdata_o", wdata_o, 32'h12345678);
    checkOutput("pass wreg_o", wreg_o, 1);
    checkOutput("pass wd_o", wd_o, 7);
    checkOutput("pass hi_o", hi_o, 32'hAAAA0001);
    checkOutput("pass lo_o", lo_o, 32'h55550002);
    checkOutput("pass whilo_o", whilo_o, 1);
    checkOutput("pass cp0_waddr_o", cp0_waddr_o, 12);
    checkOutput("pass cp0_wdata_o", cp0_wdata_o, 32'hC0C00003);
    checkOutput("pass stallreq", stallreq, 0);
    tick();
    checkOutput("pass req", dbus_req, 0);

    runAccess("lw", OP_LW, 32'h100, 32'h0, 1'b1, 32'h100, 32'hDEADBEEF, 0, 1'b0, 4'b1111, 32'h0);
    checkOutput("lw wdata_o", wdata_o, 32'hDEADBEEF);
    checkOutput("lw wreg_o", wreg_o, 1);
    checkOutput("lw bus_err", bus_err, 0);
    tick();
    applyStimulus(OP_OR, 32'h0, 32'h0, 1'b1, 32'h0BAD0001);
    checkOutput("lw after stallreq", stallreq, 0);
    checkOutput("lw after wdata_o", wdata_o, 32'h0BAD0001);

    runAccess("lb", OP_LB, 32'h103, 32'h0, 1'b1, 32'h103, 32'h000000F0, 0, 1'b0, 4'b0001, 32'h0);
    checkOutput("lb wdata_o", wdata_o, 32'hFFFFFFF0);
    tick();
    runAccess("lbu", OP_LBU, 32'h103, 32'h0, 1'b1, 32'h103, 32'h000000F0, 0, 1'b0, 4'b0001, 32'h0);
    checkOutput("lbu wdata_o", wdata_o, 32'h000000F0);
    tick();
    runAccess("lb0", OP_LB, 32'h100, 32'h0, 1'b1, 32'h100, 32'h7F80_0000, 0, 1'b0, 4'b1000, 32'h0);
    checkOutput("lb0 wdata_o", wdata_o, 32'h0000007F);
    tick();

    runAccess("sh", OP_SH, 32'h202, 32'h1234ABCD, 1'b0, 32'h202, 32'h0, 0, 1'b1, 4'b0011, 32'hABCDABCD);
    checkOutput("sh wreg_o", wreg_o, 0);
    checkOutput("sh wdata_o", wdata_o, 32'h202);
    tick();

    runAccess("lh", OP_LH, 32'h100, 32'h0, 1'b1, 32'h100, 32'h80017FFF, 2, 1'b0, 4'b1100, 32'h0);
    checkOutput("lh wdata_o", wdata_o, 32'hFFFF8001);
    tick();
    runAccess("lhu", OP_LHU, 32'h102, 32'h0, 1'b1, 32'h102, 32'h80017FFF, 1, 1'b0, 4'b0011, 32'h0);
    checkOutput("lhu wdata_o", wdata_o, 32'h00007FFF);
    tick();

    applyStimulus(OP_LW, 32'h300, 32'h0, 1'b1, 32'h300);
    checkOutput("to idle stallreq", stallreq, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("to busy req", dbus_req, 1);
      checkOutput("to busy bus_err", bus_err, 0);
    end
    tick();
    checkOutput("to hold req", dbus_req, 0);
    checkOutput("to hold bus_err", bus_err, 1);
    checkOutput("to hold wreg_o", wreg_o, 0);
    checkOutput("to hold stallreq", stallreq, 0);
    tick();
    applyStimulus(OP_OR, 32'h0, 32'h0, 1'b1, 32'h1);
    checkOutput("to after bus_err", bus_err, 0);
    checkOutput("to after wreg_o", wreg_o, 1);

    applyStimulus(OP_LW, 32'h400, 32'h0, 1'b1, 32'h400);
    tick();
    checkOutput("rst busy req", dbus_req, 1);
    rst = 1'b0;
    #1;
    checkOutput("rst held stallreq", stallreq, 0);
    tick();
    checkOutput("rst after req", dbus_req, 0);
    rst = 1'b1;
    dbus_ack = 1'b1;
    dbus_rdata = 32'hFFFF_FFFF;
    applyStimulus(OP_OR, 32'h0, 32'h0, 1'b1, 32'h2222);
    checkOutput("stray ack stallreq", stallreq, 0);
    tick();
    checkOutput("stray ack req", dbus_req, 0);
    checkOutput("stray ack wdata_o", wdata_o, 32'h2222);
    dbus_ack = 1'b0;
    runAccess("post rst", OP_LW, 32'h500, 32'h0, 1'b1, 32'h500, 32'h11223344, 0, 1'b0, 4'b1111, 32'h0);
    checkOutput("post rst wdata_o", wdata_o, 32'h11223344);
    tick();

    runAccess("hold", OP_LW, 32'h600, 32'h0, 1'b1, 32'h600, 32'hCAFEF00D, 0, 1'b0, 4'b1111, 32'h0);
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("hold stop wdata_o", wdata_o, 32'hCAFEF00D);
      checkOutput("hold stop wreg_o", wreg_o, 1);
      checkOutput("hold stop req", dbus_req, 0);
      checkOutput("hold stop stallreq", stallreq, 0);
    end
    stall = 6'd0;
    tick();
    applyStimulus(OP_OR, 32'h0, 32'h0, 1'b1, 32'h3333);
    checkOutput("hold release stallreq", stallreq, 0);
    checkOutput("hold release wdata_o", wdata_o, 32'h3333);
    applyStimulus(OP_LB, 32'h601, 32'h0, 1'b1, 32'h601);
    checkOutput("hold release idle stallreq", stallreq, 1);
    tick();
    checkOutput("hold release new req", dbus_req, 1);
    dbus_ack = 1'b1;
    dbus_rdata = 32'h00800000;
    tick();
    dbus_ack = 1'b0;
    #1;
    checkOutput("hold release lb wdata_o", wdata_o, 32'hFFFFFF80);
    tick();

`ifdef MEM_ALIGN_CHECK_EN
    applyStimulus(OP_LW, 32'h102, 32'h0, 1'b1, 32'h102);
    checkOutput("misalign stallreq", stallreq, 0);
    checkOutput("misalign bus_err", bus_err, 1);
    checkOutput("misalign wreg_o", wreg_o, 0);
    tick();
    checkOutput("misalign req", dbus_req, 0);
    applyStimulus(OP_OR, 32'h0, 32'h0, 1'b1, 32'h4);
    checkOutput("misalign after bus_err", bus_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
